// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock with the key schedule
// expanded on the fly beside the data path; done pulses when text_out updates.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no operation in flight; text_out holds the last result
// ST_ARK   | text and key captured; next edge applies the initial AddRoundKey
// ST_ROUND | rounds 1..10 in progress; round holds the round being applied
module aes128_cipher_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         done,
    output logic [127:0] text_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARK,
        ST_ROUND
    } state_t;

    state_t       fsm;
    logic [3:0]   round;
    logic [127:0] state_q;
    logic [127:0] key_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] m;
        acc = 8'h00;
        m   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ m;
            m = xtime(m);
        end
        return acc;
    endfunction

    // S-box as inversion (x^254, which also maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Ascending packed range puts FIPS byte 0 in the top bits.
    logic [0:15][7:0] st_bytes;
    logic [0:15][7:0] sb;
    logic [0:15][7:0] sr;
    logic [0:15][7:0] mc;

    assign st_bytes = state_q;

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox_f(st_bytes[i]);
        end
    end

    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    logic [127:0] round_mix;
    logic [127:0] round_last;

    assign round_mix  = mc;
    assign round_last = sr;

    // Rcon for the key being produced: round counter 0 builds k1.
    logic [7:0] rcon;

    always_comb begin
        case (round)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    logic [31:0]  sub_rot;
    logic [31:0]  w0_next;
    logic [31:0]  w1_next;
    logic [31:0]  w2_next;
    logic [31:0]  w3_next;
    logic [127:0] key_next;

    assign sub_rot  = {sbox_f(key_q[23:16]), sbox_f(key_q[15:8]),
                       sbox_f(key_q[7:0]),   sbox_f(key_q[31:24])};
    assign w0_next  = key_q[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    assign w1_next  = key_q[95:64] ^ w0_next;
    assign w2_next  = key_q[63:32] ^ w1_next;
    assign w3_next  = key_q[31:0]  ^ w2_next;
    assign key_next = {w0_next, w1_next, w2_next, w3_next};

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm      <= ST_IDLE;
            round    <= 4'd0;
            state_q  <= '0;
            key_q    <= '0;
            done     <= 1'b0;
            text_out <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_ARK: begin
                    state_q <= state_q ^ key_q;
                    key_q   <= key_next;
                    round   <= 4'd1;
                    fsm     <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (round == 4'd10) begin
                        text_out <= round_last ^ key_q;
                        done     <= 1'b1;
                        round    <= 4'd0;
                        fsm      <= ST_IDLE;
                    end else begin
                        state_q <= round_mix ^ key_q;
                        key_q   <= key_next;
                        round   <= round + 4'd1;
                    end
                end
                default: begin
                end
            endcase
            // A load overrides any round in flight; a finishing round still reports done.
            if (ld) begin
                state_q <= text_in;
                key_q   <= key;
                round   <= 4'd0;
                fsm     <= ST_ARK;
            end
        end
    end

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Randomised and directed bench for aes128_cipher_core against a software AES-128
// model with a cycle-level done/text_out expectation.
module tb_aes128_cipher_core;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld  = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] text_in = '0;
    logic         done;
    logic [127:0] text_out;

    aes128_cipher_core dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .text_in  (text_in),
        .done     (done),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] sbox_t [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] X_KEY  = 128'hcafebabedeadbeefdeadbeef00000000;
    localparam logic [127:0] X_PT   = 128'hb9648e3dc1f30548dad060fcdadf5035;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Cycle-level expectation: done 11 edges after the last load, reset wins.
    bit           m_valid = 1'b0;
    bit           m_pend  = 1'b0;
    int           m_cnt   = 0;
    logic         m_done  = 1'b0;
    logic [127:0] m_out   = '0;
    logic [127:0] m_ct    = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b1;
            m_pend  = 1'b0;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_out   = '0;
        end else begin
            m_done = 1'b0;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_out  = m_ct;
                    m_pend = 1'b0;
                end
            end
            if (ld) begin
                m_pend = 1'b1;
                m_cnt  = 11;
                m_ct   = aes_ref(key, text_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (done !== m_done) begin
                miscompares++;
                $display("FAIL cycle_done: got %b want %b at %0t", done, m_done, $time);
            end
            vectors++;
            if (text_out !== m_out) begin
                miscompares++;
                $display("FAIL cycle_text_out: got %h want %h at %0t", text_out, m_out, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] t);
        ld      = 1'b1;
        key     = k;
        text_in = t;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got no done want done within 30 cycles", name);
        end
    endtask

    task automatic run_vec(input string name, input logic [127:0] k, input logic [127:0] t,
                           input logic [127:0] want);
        int n;
        load(k, t);
        wait_done(name, n);
        chk({name, "_latency"}, 128'(n), 128'd11);
        chk({name, "_ct"}, text_out, want);
        @(negedge clk);
        chk({name, "_done_width"}, 128'(done), 128'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [127:0] rk, rt, rk2, rt2;

        build_sbox();
        chk("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        chk("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        chk("sbox_ff", 128'(sbox_t[8'hff]), 128'h16);
        chk("model_c1", aes_ref(C1_KEY, C1_PT), C1_CT);
        chk("model_appb", aes_ref(B_KEY, B_PT), B_CT);
        chk("model_zero", aes_ref('0, '0), Z_CT);

        repeat (3) @(negedge clk);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_text_out", text_out, 128'd0);
        rst = 1'b1;
        @(negedge clk);

        run_vec("c1", C1_KEY, C1_PT, C1_CT);
        run_vec("appb", B_KEY, B_PT, B_CT);
        run_vec("zero", '0, '0, Z_CT);
        run_vec("cafe", X_KEY, X_PT, aes_ref(X_KEY, X_PT));

        // restart mid-operation: second ld lands on edge 5 of the App. B run
        load(B_KEY, B_PT);
        repeat (4) @(negedge clk);
        load(C1_KEY, C1_PT);
        wait_done("restart", n);
        chk("restart_latency", 128'(n), 128'd11);
        chk("restart_ct", text_out, C1_CT);

        // reset at cycle 6, with ld also high on the reset edge
        load(X_KEY, X_PT);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ld  = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
        rst = 1'b1;
        chk("midreset_done", 128'(done), 128'd0);
        chk("midreset_text_out", text_out, 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("midreset_no_done", 128'(seen), 128'd0);

        // ld held for three edges: only the last sample counts
        ld = 1'b1; key = B_KEY; text_in = B_PT;
        @(negedge clk);
        key = X_KEY; text_in = X_PT;
        @(negedge clk);
        key = C1_KEY; text_in = C1_PT;
        @(negedge clk);
        ld = 1'b0;
        wait_done("held", n);
        chk("held_latency", 128'(n), 128'd11);
        chk("held_ct", text_out, C1_CT);

        // ld on the completion edge
        load(B_KEY, B_PT);
        repeat (10) @(negedge clk);
        load('0, '0);
        chk("overlap_done", 128'(done), 128'd1);
        chk("overlap_ct", text_out, B_CT);
        wait_done("overlap_next", n);
        chk("overlap_next_latency", 128'(n), 128'd11);
        chk("overlap_next_ct", text_out, Z_CT);

        // random loads with random gaps, some interrupting the previous run
        for (int r = 0; r < 40; r++) begin
            rk  = {$urandom, $urandom, $urandom, $urandom};
            rt  = {$urandom, $urandom, $urandom, $urandom};
            load(rk, rt);
            repeat ($urandom_range(1, 14)) @(negedge clk);
        end
        rk2 = {$urandom, $urandom, $urandom, $urandom};
        rt2 = {$urandom, $urandom, $urandom, $urandom};
        run_vec("rand_final", rk2, rt2, aes_ref(rk2, rt2));
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes128_cipher_core.md
Name: aes128_cipher_core

Overview:
- Iterative AES-128 encryption engine (FIPS-197, encrypt only).
- One round per clock; round keys expanded on the fly in parallel with the data path.
- Sits behind a host/bus wrapper: wrapper loads 128-bit key and plaintext with a single-cycle strobe, waits for a done pulse, then reads the ciphertext.

Parameters:
- None. Key size is fixed at 128 bits and round count at 10.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low
- ld  input  1  load strobe; captures key and text_in, starts encryption
- done  output  1  one-cycle pulse: text_out holds a valid ciphertext
- key  input  128  cipher key; bits [127:120] = FIPS key byte 0
- text_in  input  128  plaintext; bits [127:120] = FIPS input byte 0
- text_out  output  128  ciphertext; bits [127:120] = FIPS output byte 0

Behaviour:
- Reset: rst is synchronous and active-low; clock is clk.
  - Any rising edge with rst=0 clears state, round counter, key register and busy flag.
  - After such an edge: done=0 and text_out=0.
  - Reset mid-operation aborts the encryption; no done is produced.
- Byte mapping: state is column-major per FIPS-197. byte i = bits [127-8i : 120-8i]; column c = bytes 4c..4c+3.
- Load (edge E0, rst=1 and ld=1):
  - Register text_in and key.
  - Set busy and round counter = 0.
  - key/text_in are ignored on all other edges.
- Edge E1: state = text ^ k0 (initial AddRoundKey); round key advances to k1.
- Edges E2..E10: rounds 1..9.
  - State = MixColumns(ShiftRows(SubBytes(state))) ^ k_r.
- Edge E11: round 10, no MixColumns.
  - text_out <= SubBytes/ShiftRows result ^ k10.
  - done <= 1; busy cleared.
- Latency: done is high for exactly one cycle, after edge E11, i.e. 11 cycles after the load edge.
- text_out holds its value until the next completion or reset. It is not cleared by ld.
- Key schedule: one round key per cycle, k_r from k_(r-1).
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon_r
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- Datapath resources:
  - 16 data S-boxes plus 4 key S-boxes, purely combinational.
  - Table or composite-field implementation is allowed.
  - MixColumns uses GF(2^8) xtime with polynomial 0x11b.
- ld while busy: restarts immediately with the newly sampled key/text. The earlier operation is discarded and produces no done.
- ld held high for several cycles: every such edge re-samples and restarts. Timing counts from the last edge with ld=1.
- ld on the same edge as completion (E11): done still pulses for the finishing operation, and the new operation starts.
- rst=0 and ld=1 on the same edge: reset wins.
- No back-pressure. A done pulse not consumed is lost; text_out keeps the result.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, ld 1 cycle.
  - Required: done pulses 11 cycles later; text_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, text 3243f6a8885a308d313198a2e0370734.
  - Required: text_out = 3925841d02dc09fbdc118597196a0b32.
- All-zero key and text.
  - Required: text_out = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Key cafebabedeadbeefdeadbeef00000000, text b9648e3dc1f30548dad060fcdadf5035.
  - Required: text_out matches the software AES-128 model; done is exactly one cycle wide.
- Reassert ld at cycle 5 with the C.1 vector while an App. B encryption is running.
  - Required: no done for App. B; done 11 cycles after the second ld; C.1 ciphertext.
- Drive rst=0 at cycle 6 of an operation.
  - Required: next cycle done=0 and text_out=0; no done pulse afterward until a new ld.
